// File: rtl/param_data_memory.sv
// Byte-addressed data memory with per-byte write enables, one-cycle
// registered reads, misaligned/out-of-range error reporting and an
// automatic zeroing sweep that runs after every reset.
module param_data_memory #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] ALUresult,
   input  logic [DATA_W-1:0] WriteData,
   input  logic [DATA_W/8-1:0] ByteEn,
   output logic [DATA_W-1:0] data_result,
   output logic              rd_valid,
   output logic              err,
   output logic              busy
);

   localparam int NB  = DATA_W / 8;
   localparam int OFF = $clog2(NB);
   localparam int IW  = $clog2(DEPTH);

   localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

   localparam logic [0:0] CLEAR = 1'b0;
   localparam logic [0:0] IDLE  = 1'b1;

   logic [0:0]        state;
   logic [IW-1:0]     clr_idx;
   logic [DATA_W-1:0] mem [DEPTH];

   logic          accept;
   logic          misaligned;
   logic          out_of_range;
   logic          bad;
   logic          good_rd;
   logic          good_wr;
   logic [IW-1:0] idx;

   // Requests are only looked at once the sweep has finished; any address
   // bit above the index field makes the request out of range rather than
   // letting it alias onto a lower word.
   assign busy         = (state == CLEAR);
   assign accept       = !busy && (MemRead || MemWrite);
   assign misaligned   = (ALUresult[OFF-1:0] != '0);
   assign out_of_range = ((ALUresult >> (IW + OFF)) != '0);
   assign bad          = misaligned || out_of_range;
   assign good_rd      = accept && !bad && MemRead;
   assign good_wr      = accept && !bad && MemWrite;
   assign idx          = ALUresult[IW+OFF-1:OFF];

   // Sweep controller: walk clr_idx from 0 to the last word, then park in
   // IDLE until the next reset; the index saturates instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         clr_idx <= '0;
      end else if (state == CLEAR) begin
         if (clr_idx == LAST_IDX) begin
            state <= IDLE;
         end else begin
            clr_idx <= clr_idx + 1'b1;
         end
      end
   end

   // Storage update: the sweep owns the array while busy, otherwise good
   // writes merge only the enabled bytes into the addressed word.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == CLEAR) begin
            mem[clr_idx] <= '0;
         end else if (good_wr) begin
            for (int k = 0; k < NB; k++) begin
               if (ByteEn[k]) begin
                  mem[idx][8*k +: 8] <= WriteData[8*k +: 8];
               end
            end
         end
      end
   end

   // Read/response register: samples the pre-write word so a same-cycle
   // read and write is read-first; bad requests zero the data and pulse err.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_result <= '0;
         rd_valid    <= 1'b0;
         err         <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         err      <= 1'b0;
         if (accept && bad) begin
            err         <= 1'b1;
            data_result <= '0;
         end else if (good_rd) begin
            data_result <= mem[idx];
            rd_valid    <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_param_data_memory.sv
// Directed testbench for param_data_memory with DATA_W=16, DEPTH=256,
// ADDR_W=16.
module tb_param_data_memory;

   logic        clk = 1'b0;
   logic        rst;
   logic        MemRead;
   logic        MemWrite;
   logic [15:0] ALUresult;
   logic [15:0] WriteData;
   logic [1:0]  ByteEn;
   logic [15:0] data_result;
   logic        rd_valid;
   logic        err;
   logic        busy;

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;
   int n;
   logic errSeen;
   logic rvSeen;

   param_data_memory #(
      .DATA_W(16),
      .DEPTH (256),
      .ADDR_W(16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .ALUresult  (ALUresult),
      .WriteData  (WriteData),
      .ByteEn     (ByteEn),
      .data_result(data_result),
      .rd_valid   (rd_valid),
      .err        (err),
      .busy       (busy)
   );

   // Free-running clock, 10 time-unit period.
   always #5 clk = ~clk;

   // Drive one request for exactly one rising edge, then return the inputs
   // to idle 1 time unit after that edge.
   task automatic applyStimulus(input logic rd, input logic wr,
                                input logic [15:0] addr,
                                input logic [15:0] wdata,
                                input logic [1:0] be);
      MemRead   = rd;
      MemWrite  = wr;
      ALUresult = addr;
      WriteData = wdata;
      ByteEn    = be;
      @(posedge clk);
      #1;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      ALUresult = 16'h0000;
      WriteData = 16'h0000;
      ByteEn    = 2'b00;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic readCheck(input string tag, input logic [15:0] addr,
                            input logic [15:0] expected);
      applyStimulus(1'b1, 1'b0, addr, 16'h0000, 2'b00);
      checkOutput({tag, "_data"}, data_result, expected);
      checkOutput({tag, "_rv"}, rd_valid, 1'b1);
      checkOutput({tag, "_err"}, err, 1'b0);
   endtask

   // Directed sequence covering reset, sweep length, byte enables,
   // read-first hazard, error pulses and reset-during-sweep.
   initial begin
      rst       = 1'b1;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      ALUresult = 16'h0000;
      WriteData = 16'h0000;
      ByteEn    = 2'b00;

      applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
      applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
      checkOutput("rst_busy", busy, 1'b1);
      checkOutput("rst_rd_valid", rd_valid, 1'b0);
      checkOutput("rst_err", err, 1'b0);
      checkOutput("rst_data", data_result, 16'h0000);

      rst = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 400) begin
         applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
         n++;
      end
      checkOutput("sweep_len", n, 256);
      checkOutput("sweep_done_busy", busy, 1'b0);

      for (int i = 0; i < 256; i++) begin
         applyStimulus(1'b1, 1'b0, 16'(i * 2), 16'h0000, 2'b00);
         checkOutput("clear_read", {rd_valid, data_result}, {1'b1, 16'h0000});
      end

      applyStimulus(1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11);
      checkOutput("wr_rv", rd_valid, 1'b0);
      checkOutput("wr_err", err, 1'b0);
      readCheck("rd_beef", 16'h0010, 16'hBEEF);
      applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
      checkOutput("hold_data", data_result, 16'hBEEF);
      checkOutput("hold_rv", rd_valid, 1'b0);
      applyStimulus(1'b0, 1'b1, 16'h0010, 16'h1234, 2'b01);
      readCheck("rd_be01", 16'h0010, 16'hBE34);
      applyStimulus(1'b0, 1'b1, 16'h0010, 16'h5600, 2'b10);
      readCheck("rd_be10", 16'h0010, 16'h5634);
      applyStimulus(1'b0, 1'b1, 16'h0010, 16'hFFFF, 2'b00);
      readCheck("rd_be00", 16'h0010, 16'h5634);

      applyStimulus(1'b1, 1'b1, 16'h0020, 16'hAAAA, 2'b11);
      checkOutput("rw_same_data", data_result, 16'h0000);
      checkOutput("rw_same_rv", rd_valid, 1'b1);
      readCheck("rd_after_rw", 16'h0020, 16'hAAAA);

      applyStimulus(1'b0, 1'b1, 16'h0000, 16'h1111, 2'b11);
      readCheck("rd_pre_bad", 16'h0010, 16'h5634);
      applyStimulus(1'b1, 1'b0, 16'h0011, 16'h0000, 2'b00);
      checkOutput("misal_err", err, 1'b1);
      checkOutput("misal_rv", rd_valid, 1'b0);
      checkOutput("misal_data", data_result, 16'h0000);
      applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
      checkOutput("misal_err_clear", err, 1'b0);
      readCheck("rd_pre_oor", 16'h0020, 16'hAAAA);
      applyStimulus(1'b0, 1'b1, 16'h0200, 16'hDEAD, 2'b11);
      checkOutput("oor_err", err, 1'b1);
      checkOutput("oor_rv", rd_valid, 1'b0);
      checkOutput("oor_data", data_result, 16'h0000);
      applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
      checkOutput("oor_err_clear", err, 1'b0);
      applyStimulus(1'b0, 1'b1, 16'h0011, 16'hFFFF, 2'b11);
      checkOutput("misal_wr_err", err, 1'b1);
      applyStimulus(1'b1, 1'b0, 16'h8010, 16'h0000, 2'b00);
      checkOutput("high_addr_err", err, 1'b1);
      checkOutput("high_addr_rv", rd_valid, 1'b0);
      readCheck("mem0_kept", 16'h0000, 16'h1111);
      readCheck("mem8_kept", 16'h0010, 16'h5634);

      applyStimulus(1'b0, 1'b1, 16'h0002, 16'h5555, 2'b11);
      readCheck("rd_5555", 16'h0002, 16'h5555);
      rst = 1'b1;
      applyStimulus(1'b1, 1'b0, 16'h0002, 16'h0000, 2'b00);
      rst = 1'b0;
      checkOutput("rst_mid_rv", rd_valid, 1'b0);
      checkOutput("rst_mid_data", data_result, 16'h0000);
      checkOutput("rst_mid_busy", busy, 1'b1);
      for (int i = 0; i < 100; i++) begin
         applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
      end
      checkOutput("busy_at_100", busy, 1'b1);
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
      rst = 1'b0;

      n = 0;
      errSeen = 1'b0;
      rvSeen  = 1'b0;
      while (busy === 1'b1 && n < 400) begin
         if (n == 200) begin
            applyStimulus(1'b0, 1'b1, 16'h0002, 16'h9999, 2'b11);
         end else if (n == 201) begin
            applyStimulus(1'b1, 1'b0, 16'h0002, 16'h0000, 2'b00);
         end else if (n == 202) begin
            applyStimulus(1'b1, 1'b1, 16'h0011, 16'hFFFF, 2'b11);
         end else begin
            applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00);
         end
         if (err !== 1'b0) errSeen = 1'b1;
         if (rd_valid !== 1'b0) rvSeen = 1'b1;
         n++;
      end
      checkOutput("restart_sweep_len", n, 256);
      checkOutput("busy_err_seen", errSeen, 1'b0);
      checkOutput("busy_rv_seen", rvSeen, 1'b0);

      applyStimulus(1'b0, 1'b1, 16'h0040, 16'h4242, 2'b11);
      readCheck("rd_4242", 16'h0040, 16'h4242);
      readCheck("mem1_cleared", 16'h0002, 16'h0000);
      readCheck("mem0_cleared", 16'h0000, 16'h0000);
      readCheck("mem8_cleared", 16'h0010, 16'h0000);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/param_data_memory.md
PARAM_DATA_MEMORY -- requirements
Module: param_data_memory

Interface
REQ-001 Parameters SHALL be, one per line:
  - DATA_W, 16, word width in bits; multiple of 8, at least 16.
  - DEPTH, 256, number of words; power of two, at least 4.
  - ADDR_W, 16, byte-address width.
REQ-002 Derived constants SHALL be:
  - NB = DATA_W/8 (bytes per word)
  - OFF = log2(NB)
  - IW = log2(DEPTH)
  - Constraint: ADDR_W >= IW+OFF.
REQ-003 Ports SHALL be, one per line:
  - clk, input, 1, rising-edge clock.
  - rst, input, 1, synchronous active-high reset.
  - MemRead, input, 1, read request.
  - MemWrite, input, 1, write request.
  - ALUresult, input, ADDR_W, byte address.
  - WriteData, input, DATA_W, write data.
  - ByteEn, input, NB, per-byte write enable; bit k selects WriteData[8k+7:8k].
  - data_result, output, DATA_W, registered read data.
  - rd_valid, output, 1, data_result valid this cycle.
  - err, output, 1, previous-cycle request was misaligned or out of range.
  - busy, output, 1, clear sweep in progress; requests ignored.
REQ-004 There SHALL be one clock, clk; rst SHALL be synchronous and active-high, sampled only on the rising edge of clk.

Function
REQ-005 Storage SHALL be DEPTH words of DATA_W bits; word index = ALUresult[IW+OFF-1:OFF].
REQ-006 A request SHALL be accepted only when busy=0 and (MemRead or MemWrite)=1.
REQ-007 An accepted request SHALL be misaligned if ALUresult[OFF-1:0] != 0 and out of range if ALUresult[ADDR_W-1:IW+OFF] != 0; either condition makes it bad.
REQ-008 Bad requests SHALL NOT modify storage, SHALL set err=1 and data_result=0 the next cycle, and SHALL give rd_valid=0.
REQ-009 A good write SHALL update only bytes with ByteEn[k]=1 at the next rising edge; ByteEn=0 SHALL leave the word unchanged.
REQ-010 A good read SHALL yield data_result=mem[index] and rd_valid=1 exactly one cycle after acceptance (latency 1).
REQ-011 Without a new accepted read, data_result SHALL hold its last value and rd_valid SHALL return to 0.
REQ-012 Simultaneous good read and write to the same index SHALL be read-first: data_result gets the pre-write contents; storage gets the merged data.
REQ-013 A read in the cycle immediately after a write to the same index SHALL return the written data.
REQ-014 err SHALL be 1 for exactly one cycle per bad accepted request, else 0.
REQ-015 FSM states SHALL be CLEAR and IDLE.
  - CLEAR: writes 0 to mem[clr_idx] each cycle, clr_idx increments, busy=1.
  - CLEAR to IDLE when clr_idx = DEPTH-1 after that word is zeroed.
  - IDLE: busy=0; remains IDLE until rst.
REQ-016 clr_idx SHALL be IW bits wide and SHALL NOT wrap in CLEAR; the sweep takes exactly DEPTH cycles after rst deasserts.
REQ-017 Requests presented while busy=1 SHALL be dropped silently: no storage change, rd_valid=0, err=0.
REQ-018 Address bits above IW+OFF SHALL never alias into the index.

Reset
REQ-019 While rst=1 at a rising edge: state=CLEAR, clr_idx=0, data_result=0, rd_valid=0, err=0, busy=1.
REQ-020 rst asserted mid-sweep or mid-request SHALL restart the sweep from index 0 and discard any pending read result.
REQ-021 Storage contents SHALL be all-zero on completion of each sweep; no other initialisation is relied upon.

Verification (DATA_W=16, DEPTH=256, ADDR_W=16)
REQ-022 rst for 1 cycle, then idle -> busy=1 for exactly 256 cycles, then 0; a read of every address returns 0x0000.
REQ-023 Write 0xBEEF at 0x0010 with ByteEn=11, then read 0x0010 -> next cycle data_result=0xBEEF, rd_valid=1; then write 0x1234 with ByteEn=01 and read -> 0xBE34.
REQ-024 Same cycle: read+write 0x0020 (old 0x0000, new 0xAAAA) -> data_result=0x0000; next-cycle read -> 0xAAAA.
REQ-025 Read 0x0011 (misaligned) and write 0x0200 (out of range) -> err=1 one cycle each, rd_valid=0, data_result=0; mem[0] and mem[0x08] are unchanged.
REQ-026 Write 0x5555 at 0x0002, rst at sweep cycle 100, then requests during busy -> all dropped; after 256 further cycles mem[1] reads 0x0000, err never set.
